inst_queue: RTL
===============

// Module: inst_queue
// PURPOSE
//  Fetch-to-decode instruction queue. Buffers {pc, inst, fetch exception} from the IF stage and presents
//  the oldest entry to the ID stage, whose decoder consumes the inst word. Valid/ready on both sides.
//  A single-cycle flush discards all entries on exception, eret or redirect.
// PARAMETERS
//  DEPTH    8    entry count; power of two, >= 2
//  PTR_W    $clog2(DEPTH)    localparam; pointer index width
// PORTS
//  clk           in   1        single clock, rising edge
//  reset         in   1        synchronous, active-high
//  flush         in   1        discard all entries and any same-cycle push/pop
//  if_valid      in   1        IF presents an entry
//  if_ready      out  1        queue accepts the entry this cycle
//  if_pc         in   32       fetch PC
//  if_inst       in   32       fetched instruction word
//  if_ex         in   fetch_ex_t   fetch exception {adel, tlb_refill, tlb_invalid}
//  id_valid      out  1        head entry is valid for ID
//  id_ready      in   1        ID takes the head this cycle
//  id_pc         out  32       head PC
//  id_inst       out  32       head instruction word; drives inst_decoder.inst
//  id_ex         out  fetch_ex_t   head fetch exception
//  occupancy     out  PTR_W+1  current entry count, 0..DEPTH
// BEHAVIOUR
//  - Reset: wr_ptr = rd_ptr = 0 and count = 0 at the edge. While reset is high, if_ready = 0 and id_valid = 0.
//    Array contents are not reset. id_pc, id_inst and id_ex are don't-care while id_valid = 0.
//  - Pointers are PTR_W+1 bits with a wrap bit. Empty: ptrs equal. Full: index bits equal and wrap bits differ.
//    Pointers increment modulo 2*DEPTH.
//  - Push fires when if_valid & if_ready. if_ready = ~full & ~flush & ~reset. if_ready has no combinational
//    dependence on id_ready, so a full queue stalls IF even if ID pops in the same cycle.
//  - Pop fires when id_valid & id_ready. id_valid = ~empty & ~flush & ~reset.
//    id_* = array[rd_ptr], read combinationally from registered state.
//  - Push and pop in the same cycle: both take effect and count is unchanged. This is legal when empty
//    only under bypass (see CONFIGURATION).
//  - Latency (no bypass): an entry pushed in cycle N is visible at ID in cycle N+1. Throughput is 1 entry/cycle.
//  - Flush in cycle N:
//    - id_valid and if_ready are forced to 0 in cycle N.
//    - At the edge, the pointers and count clear; a push or pop in cycle N has no effect.
//    - The queue is empty in cycle N+1.
//  - Reset asserted mid-stream: same effect as flush; reset has priority over flush.
//  - Ordering is strict FIFO. No entry is dropped or duplicated except by flush or reset.
//  - An entry with a nonzero if_ex is queued like any other. ID raises the exception.
// CONFIGURATION
//  - IQ_BYPASS_EN defined:
//    - When empty & ~flush & ~reset & if_valid: id_valid = 1 and id_* = if_* in the same cycle
//      (zero-latency bypass).
//    - If id_ready is also 1, the entry is consumed and not written; count stays 0.
//    - If id_ready is 0, the entry is written normally and becomes the head in the next cycle.
//  - IQ_BYPASS_EN undefined: no combinational path from the if_* inputs to id_*. Minimum latency is 1 cycle.
// STRUCTURE
//  - cpu_defs.svh (shared):
//    - typedef fetch_ex_t: packed struct {adel, tlb_refill, tlb_invalid}
//    - typedef iq_entry_t: packed struct {pc, inst, ex}
//    - constant IQ_DEPTH_DEFAULT = 8
//  - Sub-module inst_queue_ram: DEPTH x $bits(iq_entry_t) array.
//    - Write port: synchronous, enabled by push (masked by flush and reset).
//    - Read port: asynchronous, indexed by rd_ptr.
//  - inst_queue itself holds the pointers, the full/empty logic, the handshake and the bypass mux.
// TESTING
//  1. After reset, push pc=0xBFC00000, inst=0x24080001 with id_ready=0.
//     Next cycle: id_valid=1, id_inst=0x24080001, occupancy=1.
//  2. Push DEPTH entries with inst=i and id_ready=0. Then: if_ready=0 and occupancy=8.
//     Next, hold id_ready=1: entries pop in order 0..7, then id_valid=0.
//  3. Full queue, push and pop both requested in the same cycle: the pop occurs, the push is refused
//     (if_ready=0) and occupancy becomes 7.
//  4. Three entries queued, flush=1 together with if_valid=1.
//     Same cycle: id_valid=0 and if_ready=0. Next cycle: occupancy=0 and id_valid=0.
//  5. Entry with if_ex.adel=1, pc=0x00000003: it emerges with id_ex.adel=1 and id_pc=0x00000003, unaltered.
//  6. IQ_BYPASS_EN, empty queue, if_valid=1 and id_ready=1: id_valid=1 and id_inst=if_inst in the same cycle,
//     and occupancy stays 0. Without the macro, id_valid only rises the following cycle.
//  - Random push/pop/flush stress with a scoreboard: FIFO order holds and occupancy matches the model.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// Holds the fetch exception flags, the queued entry layout and the default depth.
package inst_queue_pkg;

    typedef struct packed {
        logic adel;
        logic tlb_refill;
        logic tlb_invalid;
    } fetch_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        fetch_ex_t   ex;
    } iq_entry_t;

    localparam int IQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/inst_queue_if.sv
// Valid/ready instruction channel carrying {pc, inst, fetch exception}.
// One instance is used on the IF side and another on the ID side of the queue.
interface inst_queue_if
    import inst_queue_pkg::*;
;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] inst;
    fetch_ex_t   ex;

    modport master (output valid, output pc, output inst, output ex, input ready);
    modport slave  (input valid, input pc, input inst, input ex, output ready);

endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage for inst_queue: synchronous write port, asynchronous read port.
// Contents are deliberately left unreset.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  iq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output iq_entry_t        rd_data
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with wrap-bit pointers and single-cycle flush.
// Define IQ_BYPASS_EN to let an entry pass straight from IF to ID when the queue is empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    inst_queue_if.slave                fetch,
    inst_queue_if.master               decode,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           bypass_hit;
    logic           bypass_consume;
    logic           wr_en;
    logic           rd_adv;
    iq_entry_t      wr_entry;
    iq_entry_t      head_entry;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    // if_ready must not look at id_ready, so a full queue stalls IF even when ID pops.
    assign fetch.ready = ~full & ~flush & ~reset;

`ifdef IQ_BYPASS_EN
    assign bypass_hit = empty & fetch.valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign decode.valid = (~empty | bypass_hit) & ~flush & ~reset;

    assign push = fetch.valid & fetch.ready;
    assign pop  = decode.valid & decode.ready;

    // A bypassed entry taken by ID the same cycle never touches storage or pointers.
    assign bypass_consume = bypass_hit & pop;
    assign wr_en          = push & ~bypass_consume;
    assign rd_adv         = pop & ~bypass_consume;

    assign wr_entry = '{pc: fetch.pc, inst: fetch.inst, ex: fetch.ex};

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[PTR_W-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[PTR_W-1:0]),
        .rd_data (head_entry)
    );

`ifdef IQ_BYPASS_EN
    assign decode.pc   = bypass_hit ? fetch.pc   : head_entry.pc;
    assign decode.inst = bypass_hit ? fetch.inst : head_entry.inst;
    assign decode.ex   = bypass_hit ? fetch.ex   : head_entry.ex;
`else
    assign decode.pc   = head_entry.pc;
    assign decode.inst = head_entry.inst;
    assign decode.ex   = head_entry.ex;
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Pointer difference modulo 2*DEPTH spans 0..DEPTH thanks to the wrap bit.
    assign occupancy = wr_ptr - rd_ptr;

endmodule
